// File: rtl/stream_rr_arbiter.sv
// Four-port round-robin, packet-locking arbiter for src_rdy/dst_rdy streams.
// Optional stall watchdog: define STREAM_ARB_WATCHDOG_EN to enable it.
module stream_rr_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [4*WIDTH-1:0] datain,
  input  logic [3:0]         eofin,
  input  logic [3:0]         src_rdy_i,
  output logic [3:0]         dst_rdy_o,
  output logic [WIDTH-1:0]   dataout,
  output logic               eofout,
  output logic               src_rdy_o,
  input  logic               dst_rdy_i,
  output logic [3:0]         grant,
  output logic               timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state_reg;
  logic [3:0] grant_reg;
  logic [1:0] owner_reg;
  logic [1:0] last_reg;

  logic [1:0] pick_idx;
  logic       pick_valid;
  logic [1:0] cand;
  logic       busy;
  logic       out_beat;
  logic       eof_beat;
  logic       wd_fire;

  // Walk from the farthest candidate back to last+1 so the nearest requester wins.
  always_comb begin
    pick_idx   = last_reg;
    pick_valid = 1'b0;
    cand       = last_reg;
    for (int k = 4; k >= 1; k--) begin
      cand = 2'(last_reg + 2'(k));
      if (src_rdy_i[cand]) begin
        pick_idx   = cand;
        pick_valid = 1'b1;
      end
    end
  end

  assign busy      = (state_reg == BUSY);
  assign dataout   = datain[owner_reg*WIDTH +: WIDTH];
  assign eofout    = eofin[owner_reg];
  assign src_rdy_o = busy & src_rdy_i[owner_reg];
  assign out_beat  = src_rdy_o & dst_rdy_i;
  assign eof_beat  = out_beat & eofout;
  assign grant     = grant_reg;

  // grant_reg is all-zero while idle, so every port sees ready low then.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dst_rdy
      assign dst_rdy_o[gi] = grant_reg[gi] & dst_rdy_i;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_reg <= IDLE;
      grant_reg <= 4'b0000;
      owner_reg <= 2'd0;
      last_reg  <= 2'd3;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_valid) begin
            grant_reg <= 4'b0001 << pick_idx;
            owner_reg <= pick_idx;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (eof_beat || wd_fire) begin
            last_reg  <= owner_reg;
            grant_reg <= 4'b0000;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef STREAM_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] wd_count_reg;
  logic       timeout_reg;

  // Fires on the TIMEOUT-th consecutive stalled BUSY cycle.
  assign wd_fire = busy & ~out_beat & (wd_count_reg == WD_LIMIT);
  assign timeout = timeout_reg;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wd_count_reg <= 8'd0;
      timeout_reg  <= 1'b0;
    end else begin
      timeout_reg <= wd_fire;
      if (!busy || out_beat || wd_fire)
        wd_count_reg <= 8'd0;
      else
        wd_count_reg <= wd_count_reg + 8'd1;
    end
  end
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;

  // TIMEOUT only matters for the watchdog build; keep the range visible here.
  if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_timeout_out_of_range
  end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter; the watchdog case runs only when
// STREAM_ARB_WATCHDOG_EN is defined (instance uses TIMEOUT=8).
module tb_stream_rr_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         clear = 1'b0;
  logic [W-1:0] pdata [4];
  logic [4*W-1:0] datain;
  logic [3:0]   eofin = 4'b0000;
  logic [3:0]   src_rdy_i = 4'b0000;
  logic [3:0]   dst_rdy_o;
  logic [W-1:0] dataout;
  logic         eofout;
  logic         src_rdy_o;
  logic         dst_rdy_i = 1'b1;
  logic [3:0]   grant;
  logic         timeout;

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int snap;
  int b;

  assign datain = {pdata[3], pdata[2], pdata[1], pdata[0]};

  always #5 clk = ~clk;

  stream_rr_arbiter #(.WIDTH(W), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .datain(datain), .eofin(eofin), .src_rdy_i(src_rdy_i),
    .dst_rdy_o(dst_rdy_o), .dataout(dataout), .eofout(eofout),
    .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
    .grant(grant), .timeout(timeout)
  );

  always @(posedge clk) begin
    if (!reset && !clear && src_rdy_o && dst_rdy_i) begin
      beats <= beats + 1;
      $display("beat: grant=%b data=%02h eof=%0d", grant, dataout, eofout);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 4; p++) pdata[p] = 8'h00;

    // Reset state
    step();
    mid();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_src_rdy_o", 32'(src_rdy_o), 32'h0);
    check("rst_dst_rdy_o", 32'(dst_rdy_o), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    step();
    reset = 1'b0;

    // 1: port 2 alone, 3-beat packet
    snap = beats;
    src_rdy_i = 4'b0100; pdata[2] = 8'h21;
    mid();
    check("t1_idle_grant", 32'(grant), 32'h0);
    check("t1_idle_src_rdy_o", 32'(src_rdy_o), 32'h0);
    step();
    mid();
    check("t1_grant", 32'(grant), 32'h4);
    check("t1_dst_rdy_o", 32'(dst_rdy_o), 32'h4);
    check("t1_data1", 32'(dataout), 32'h21);
    step();
    pdata[2] = 8'h22;
    mid();
    check("t1_data2", 32'(dataout), 32'h22);
    step();
    pdata[2] = 8'h23; eofin[2] = 1'b1;
    mid();
    check("t1_data3", 32'(dataout), 32'h23);
    check("t1_eof", 32'(eofout), 32'h1);
    step();
    src_rdy_i = 4'b0000; eofin = 4'b0000;
    mid();
    check("t1_release", 32'(grant), 32'h0);
    check("t1_beats", 32'(beats - snap), 32'd3);

    // 2: all ports, single-beat packets, from fresh reset
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    src_rdy_i = 4'b1111; eofin = 4'b1111;
    for (int p = 0; p < 4; p++) pdata[p] = 8'(8'hA0 + p);
    for (int i = 0; i < 5; i++) begin
      mid();
      check("t2_idle", 32'(grant), 32'h0);
      step();
      mid();
      check("t2_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
      check("t2_data", 32'(dataout), 32'(8'hA0 + (i % 4)));
      step();
    end

    // 3: port 1 arrives mid-packet on port 0 and must wait
    src_rdy_i = 4'b0001; eofin = 4'b0000; pdata[0] = 8'h40;
    mid();
    check("t3_idle", 32'(grant), 32'h0);
    step();
    mid();
    check("t3_grant0", 32'(grant), 32'h1);
    check("t3_data1", 32'(dataout), 32'h40);
    step();
    pdata[0] = 8'h41; src_rdy_i[1] = 1'b1; eofin[1] = 1'b1; pdata[1] = 8'h51;
    mid();
    check("t3_dst_b2", 32'(dst_rdy_o), 32'h1);
    step();
    pdata[0] = 8'h42;
    mid();
    check("t3_dst_b3", 32'(dst_rdy_o), 32'h1);
    step();
    pdata[0] = 8'h43; eofin[0] = 1'b1;
    mid();
    check("t3_dst_b4", 32'(dst_rdy_o), 32'h1);
    check("t3_eof", 32'(eofout), 32'h1);
    step();
    src_rdy_i[0] = 1'b0; eofin[0] = 1'b0;
    mid();
    check("t3_gap_dst", 32'(dst_rdy_o), 32'h0);
    check("t3_gap_grant", 32'(grant), 32'h0);
    step();
    mid();
    check("t3_grant1", 32'(grant), 32'h2);
    check("t3_data_p1", 32'(dataout), 32'h51);
    step();
    src_rdy_i = 4'b0000; eofin = 4'b0000;

    // 4: consumer toggles ready during a 5-beat packet on port 3
    snap = beats;
    b = 0;
    src_rdy_i = 4'b1000; pdata[3] = 8'h30;
    mid();
    check("t4_idle", 32'(grant), 32'h0);
    step();
    for (int cyc = 0; cyc < 20 && b < 5; cyc++) begin
      pdata[3] = 8'(8'h30 + b);
      eofin[3] = (b == 4);
      dst_rdy_i = (cyc % 2 == 0);
      mid();
      check("t4_owner", 32'(grant), 32'h8);
      if (dst_rdy_i) begin
        check("t4_data", 32'(dataout), 32'(8'h30 + b));
        b++;
      end
      step();
    end
    src_rdy_i = 4'b0000; eofin = 4'b0000; dst_rdy_i = 1'b1;
    mid();
    check("t4_beats", 32'(beats - snap), 32'd5);
    check("t4_release", 32'(grant), 32'h0);
    step();

    // 5: reset mid-packet on port 3, then 0 beats 3 on a tie
    src_rdy_i = 4'b1000; pdata[3] = 8'h60;
    mid();
    check("t5_idle", 32'(grant), 32'h0);
    step();
    mid();
    check("t5_grant3", 32'(grant), 32'h8);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; src_rdy_i = 4'b1001; pdata[0] = 8'h70;
    mid();
    check("t5_rst_grant", 32'(grant), 32'h0);
    check("t5_rst_src_rdy_o", 32'(src_rdy_o), 32'h0);
    step();
    mid();
    check("t5_grant0", 32'(grant), 32'h1);
    check("t5_data", 32'(dataout), 32'h70);
    clear = 1'b1;
    step();
    clear = 1'b0; src_rdy_i = 4'b0000;
    mid();
    check("t5_clear_grant", 32'(grant), 32'h0);
    step();

`ifdef STREAM_ARB_WATCHDOG_EN
    // 6: owner goes silent; watchdog releases after 8 stalled cycles
    src_rdy_i = 4'b0010;
    mid();
    check("t6_idle", 32'(grant), 32'h0);
    step();
    src_rdy_i = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      mid();
      check("t6_hold", 32'(grant), 32'h2);
      check("t6_no_pulse", 32'(timeout), 32'h0);
      step();
    end
    src_rdy_i = 4'b0100; eofin[2] = 1'b1;
    mid();
    check("t6_pulse", 32'(timeout), 32'h1);
    check("t6_release", 32'(grant), 32'h0);
    step();
    mid();
    check("t6_pulse_end", 32'(timeout), 32'h0);
    check("t6_next_grant", 32'(grant), 32'h4);
    step();
    src_rdy_i = 4'b0000; eofin = 4'b0000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
